i2c_byte_tx: RTL and testbench

- Downstream consumer of the SPI shift-register stage. Takes each byte the SPI slave delivers and writes it to a fixed I2C slave as a single-master transaction: START, address+W, ACK, data, ACK, STOP.
- Drives open-drain SCL/SDA enables for the board pads.
- Write-only master. No clock stretching, no arbitration, no repeated START.

---
 rtl/i2c_byte_tx_pkg.sv | 33 +++
 rtl/i2c_byte_tx_tick.sv | 38 +++
 rtl/i2c_byte_tx.sv | 146 ++++++++++++++
 tb/tb_i2c_byte_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_byte_tx_pkg.sv
// Shared definitions for the single-byte I2C write master: FSM state
// encoding, counter widths and the pad-drive decode per phase/quarter.
package i2c_byte_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        STOP
    } state_t;

    localparam int QW = 2;   // quarter index width (q0..q3)
    localparam int BW = 3;   // bit counter width (bit 0..7)

    // Open-drain enables {scl_oe, sda_oe} for a given phase and quarter.
    // tx_bit is the bit currently at the head of the shift register.
    function automatic logic [1:0] pad_drive(state_t st, logic [QW-1:0] q, logic tx_bit);
        logic [1:0] drive;
        drive = 2'b00;
        case (st)
            START:              drive = {1'b0, q[1]};
            ADDR, DATA:         drive = {~q[1], ~tx_bit};
            ADDR_ACK, DATA_ACK: drive = {~q[1], 1'b0};
            STOP:               drive = {~q[1], (q != 2'd3)};
            default:            drive = 2'b00;
        endcase
        return drive;
    endfunction

endpackage

// File: rtl/i2c_byte_tx_tick.sv
// Quarter-period tick generator: counts 0..CLK_DIV-1 while run is high,
// parked at 0 otherwise; tick marks the last cycle of each quarter.
module i2c_tick_gen #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == LAST);

    // Next count: wrap on tick, hold at zero when not running.
    always_comb begin
        cnt_d = cnt_q;
        if (!run || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_byte_tx.sv
// Write-only single-master I2C byte transmitter. Each accepted byte becomes
// START, SLAVE_ADDR+W, ACK, data, ACK, STOP on open-drain SCL/SDA enables.
// Handshake: a byte is taken on the clock edge where din_valid && din_ready;
// din_ready is high only in IDLE, so din_valid while busy is simply ignored.
module i2c_byte_tx
    import i2c_byte_tx_pkg::*;
#(
    parameter int         CLK_DIV    = 250,
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i,
    output logic [2:0] state_o
);

    state_t          state_q, state_d;
    logic [QW-1:0]   q_q, q_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      sh_q, sh_d;
    logic            ack_err_q, ack_err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            scl_q, scl_d;
    logic            sda_q, sda_d;
    logic            tick;
    logic            run;
    logic            accept;
    logic            ack_phase;

    assign run       = (state_q != IDLE);
    assign din_ready = (state_q == IDLE) && !rst;
    assign accept    = din_valid && din_ready;
    assign ack_phase = (state_q == ADDR_ACK) || (state_q == DATA_ACK);

    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign scl_oe  = scl_q;
    assign sda_oe  = sda_q;
    assign state_o = state_q;

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .tick (tick)
    );

    // Next-state: advance one quarter per tick; phase changes at end of q3.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        bit_d     = bit_q;
        data_d    = data_q;
        sh_d      = sh_q;
        ack_err_d = ack_err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (state_q == IDLE) begin
            if (accept) begin
                state_d   = START;
                q_d       = '0;
                bit_d     = '0;
                data_d    = din;
                sh_d      = {SLAVE_ADDR, 1'b0};
                ack_err_d = 1'b0;
                busy_d    = 1'b1;
            end
        end else if (tick) begin
            q_d = q_q + 1'b1;
            // The slave's ACK is sampled while SCL is high, at the end of q2.
            if (ack_phase && (q_q == 2'd2) && sda_i) begin
                ack_err_d = 1'b1;
            end
            if (q_q == 2'd3) begin
                case (state_q)
                    START: state_d = ADDR;
                    ADDR, DATA: begin
                        sh_d  = {sh_q[6:0], 1'b0};
                        bit_d = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
                        end
                    end
                    ADDR_ACK: begin
                        if (ack_err_q) begin
                            state_d = STOP;
                        end else begin
                            state_d = DATA;
                            sh_d    = data_q;
                        end
                    end
                    DATA_ACK: state_d = STOP;
                    STOP: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
        // Pad enables are registered for the position being entered.
        {scl_d, sda_d} = pad_drive(state_d, q_d, sh_d[7]);
    end

    // FSM, datapath and registered pad outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            q_q       <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            sh_q      <= '0;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b0;
            sda_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            sh_q      <= sh_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
        end
    end

endmodule

// File: tb/tb_i2c_byte_tx.sv
// Bench for i2c_byte_tx: open-drain slave with pull-up, bus decoder,
// scoreboard of expected transactions from a transaction-level model.
module tb_i2c_byte_tx;

    localparam int         CLK_DIV    = 4;
    localparam logic [6:0] SLAVE_ADDR = 7'h50;
    localparam int         W          = 31;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, busy, done, ack_err, scl_oe, sda_oe, sda_i;
    logic [2:0] state_dbg;

    logic       slave_pull = 1'b0;
    logic       slave_ack_addr, slave_ack_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_done = 0;
    int last_acc_cyc = 0;
    int last_done_cyc = 0;

    logic [W-1:0] exp_q[$];
    logic [8:0]   dec_q[$];
    int           bit_n = 0;
    logic [7:0]   sh = '0;
    int           starts = 0;
    int           stops = 0;
    logic         prev_scl = 1'b1;
    logic         prev_sda = 1'b1;
    logic         done_prev = 1'b0;

    assign sda_i = !(sda_oe || slave_pull);

    i2c_byte_tx #(
        .CLK_DIV    (CLK_DIV),
        .SLAVE_ADDR (SLAVE_ADDR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .sda_i     (sda_i),
        .state_o   (state_dbg)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: bytes seen on the bus, ACK levels,
    // final ack_err and acceptance-to-done latency.
    function automatic logic [W-1:0] model(input logic [7:0] d, input logic ack_a, input logic ack_d);
        int         quarters;
        logic [8:0] b0, b1;
        logic [1:0] n;
        logic       err;
        b0 = {SLAVE_ADDR, 1'b0, ~ack_a};
        if (ack_a) begin
            n = 2'd2; b1 = {d, ~ack_d}; err = ~ack_d;
            quarters = 4 + 2 * 9 * 4 + 4;
        end else begin
            n = 2'd1; b1 = '0; err = 1'b1;
            quarters = 4 + 9 * 4 + 4;
        end
        return {err, 10'(quarters * CLK_DIV), n, b0, b1};
    endfunction

    // acceptance observer
    always @(posedge clk) begin
        if (!rst && din_valid && din_ready) begin
            last_acc_cyc = cyc + 1;
            n_acc++;
        end
    end

    // monitor: slave model, bus decoder, scoreboard compare on done
    always @(negedge clk) begin : monitor
        logic scl_l, sda_l;
        logic [W-1:0] e;
        logic [8:0] a0, a1;
        if (rst) begin
            dec_q.delete();
            bit_n = 0; sh = '0; starts = 0; stops = 0;
            slave_pull = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1; done_prev = 1'b0;
        end else begin
            scl_l = !scl_oe;
            sda_l = !(sda_oe || slave_pull);
            if (prev_scl && scl_l && prev_sda && !sda_l) begin
                starts++; bit_n = 0;
            end else if (prev_scl && scl_l && !prev_sda && sda_l) begin
                stops++;
            end else if (!prev_scl && scl_l) begin
                if (bit_n < 8) sh = {sh[6:0], sda_l};
                else dec_q.push_back({sh, sda_l});
                bit_n = (bit_n == 8) ? 0 : bit_n + 1;
            end else if (prev_scl && !scl_l) begin
                if (bit_n == 8) slave_pull = (dec_q.size() == 0) ? slave_ack_addr : slave_ack_data;
                else slave_pull = 1'b0;
            end
            prev_scl = scl_l;
            prev_sda = !(sda_oe || slave_pull);
            if (done_prev) check("done_width", 32'(done), 32'd0);
            if (done) begin
                n_done++;
                last_done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
                end else begin
                    e  = exp_q.pop_front();
                    a0 = (dec_q.size() > 0) ? dec_q[0] : 9'h0;
                    a1 = (dec_q.size() > 1) ? dec_q[1] : 9'h0;
                    check("ack_err", 32'(ack_err), 32'(e[30]));
                    check("latency", 32'(cyc - last_acc_cyc), 32'(e[29:20]));
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("starts", 32'(starts), 32'd1);
                    check("stops", 32'(stops), 32'd1);
                    check("nbytes", 32'(dec_q.size()), 32'(e[19:18]));
                    check("byte0_ack", 32'(a0), 32'(e[17:9]));
                    check("byte1_ack", 32'(a1), 32'(e[8:0]));
                end
                dec_q.delete();
                starts = 0;
                stops = 0;
            end
            done_prev = done;
        end
    end

    // driver tasks
    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (din_ready) return;
        end
        checks++; errors++;
        $display("FAIL idle_timeout actual=busy expected=idle (t=%0t)", $time);
    endtask

    task automatic send(input logic [7:0] d, input logic ack_a, input logic ack_d);
        wait_idle();
        slave_ack_addr = ack_a;
        slave_ack_data = ack_d;
        exp_q.push_back(model(d, ack_a, ack_d));
        din = d;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
    endtask

    task automatic wait_done();
        int base;
        base = n_done;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (n_done != base) return;
        end
        checks++; errors++;
        $display("FAIL done_timeout actual=no_done expected=done (t=%0t)", $time);
    endtask

    // stimulus
    initial begin
        int   base;
        logic got;
        logic [7:0] d;
        logic a, dd;

        rst = 1'b0; din = '0; din_valid = 1'b0;
        slave_ack_addr = 1'b1; slave_ack_data = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_scl_oe", 32'(scl_oe), 32'd0);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check("rst_din_ready", 32'(din_ready), 32'd1);
        check("rst_state", 32'(state_dbg), 32'd0);

        // full write with ACKs
        send(8'hA5, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("ready_while_busy", 32'(din_ready), 32'd0);
        wait_done();
        repeat (2) @(negedge clk);
        check("ack_err_after_ok", 32'(ack_err), 32'd0);

        // address NACK
        send(8'hFF, 1'b0, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);
        check("ack_err_hold", 32'(ack_err), 32'd1);

        // reset while idle clears ack_err without a clock edge
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("idle_rst_ack_err", 32'(ack_err), 32'd0);
        check("idle_rst_scl_oe", 32'(scl_oe), 32'd0);
        check("idle_rst_sda_oe", 32'(sda_oe), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check("idle_rst_din_ready", 32'(din_ready), 32'd1);

        // data NACK, then next byte clears ack_err
        send(8'h77, 1'b1, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);
        check("ack_err_data_nack", 32'(ack_err), 32'd1);
        send(8'h12, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("ack_err_cleared", 32'(ack_err), 32'd0);
        wait_done();

        // din_valid held during a busy transaction
        send(8'h5A, 1'b1, 1'b1);
        base = n_acc;
        din = 8'h3C;
        din_valid = 1'b1;
        exp_q.push_back(model(8'h3C, 1'b1, 1'b1));
        repeat (10) @(negedge clk);
        check("held_not_ready", 32'(din_ready), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 1500 && !got; i++) begin
            @(negedge clk);
            if (n_acc != base) got = 1'b1;
        end
        din_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL held_accept_timeout actual=none expected=accept (t=%0t)", $time);
        end else begin
            check("held_accept_gap", 32'(last_acc_cyc - last_done_cyc), 32'd1);
            wait_done();
        end

        // reset during DATA bit 4 (q1 of a zero bit: both lines pulled low)
        send(8'h00, 1'b1, 1'b1);
        repeat (230) @(posedge clk);
        #2;
        check("pre_rst_scl_oe", 32'(scl_oe), 32'd1);
        check("pre_rst_sda_oe", 32'(sda_oe), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_scl_oe", 32'(scl_oe), 32'd0);
        check("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        send(8'h01, 1'b1, 1'b1);
        wait_done();

        // randomized transactions
        for (int k = 0; k < 8; k++) begin
            d  = 8'($urandom_range(0, 255));
            a  = ($urandom_range(0, 3) != 0);
            dd = ($urandom_range(0, 3) != 0);
            send(d, a, dd);
            wait_done();
            repeat (2) @(negedge clk);
            check("rand_ack_err", 32'(ack_err), 32'(!a || !dd));
        end

        repeat (5) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
